// File: rtl/tx_pkg.sv
// Shared types and limits for the serial transmit path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } tx_state_t;

    // Payload width of the serial transmitter.
    localparam int TX_DATA_W = 7;

    // Start bit + 8 data/parity bits + stop bit + 1 turnaround cycle.
    localparam int TX_FRAME_MIN = 11;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request searching ptr, ptr+1, ... with wrap.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when to consume the pick.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               any,
    output logic [IDX_W-1:0]   idx
);

    logic [NUM_REQ-1:0] rot;

    // Rotate so the search start sits at bit 0, take the lowest set bit, then undo the rotation.
    always_comb begin
        int sum;
        sum = 0;
        any = 1'b0;
        idx = '0;
        rot = NUM_REQ'({req, req} >> ptr);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!any && rot[k]) begin
                any = 1'b1;
                sum = int'(ptr) + k;
                if (sum >= NUM_REQ) begin
                    sum = sum - NUM_REQ;
                end
                idx = IDX_W'(sum);
            end
        end
    end

endmodule

// File: rtl/tx_scheduler.sv
// Round-robin scheduler sharing one serial transmitter; times each frame plus idle gap itself.
// Latency: request seen in an IDLE cycle -> tx_start/req_ack on the next cycle.
// Backpressure: requesters hold valid+data until req_ack; no grants while busy or enable is low.
module tx_scheduler
    import tx_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 7,
    parameter int FRAME_CYCLES = 11,
    parameter int GAP_CYCLES   = 0
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        enable,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ack,
    output logic                        tx_start,
    output logic [DATA_W-1:0]           tx_data,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        busy,
    output logic                        frame_done
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int TOTAL = FRAME_CYCLES + GAP_CYCLES;
    localparam int CNT_W = $clog2(TOTAL);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TOTAL - 1);

    if (FRAME_CYCLES < TX_FRAME_MIN) begin : g_frame_chk
        $error("tx_scheduler: FRAME_CYCLES below transmitter frame length");
    end
    if (DATA_W != TX_DATA_W) begin : g_width_chk
        $error("tx_scheduler: DATA_W must match transmitter width");
    end
    if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_req_chk
        $error("tx_scheduler: NUM_REQ out of range 2..16");
    end

    tx_state_t          state;
    tx_state_t          state_nxt;
    logic [IDX_W-1:0]   ptr;
    logic [CNT_W-1:0]   cnt;
    logic               arb_any;
    logic [IDX_W-1:0]   arb_idx;
    logic               grant;
    logic [DATA_W-1:0]  req_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign req_arr[i] = req_data[i*DATA_W +: DATA_W];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req (req_valid),
        .ptr (ptr),
        .any (arb_any),
        .idx (arb_idx)
    );

    // Arbitration result only matters in IDLE; enable gates new grants but never an active frame.
    assign grant = (state == IDLE) && enable && arb_any;

    // State register; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: one SEND cycle, then WAIT until the frame+gap counter drains.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = SEND;
            SEND:    state_nxt = WAIT;
            WAIT:    if (cnt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered outputs, pointer and frame counter; pulses default low every cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_start   <= 1'b0;
            tx_data    <= '0;
            req_ack    <= '0;
            grant_id   <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            ptr        <= '0;
            cnt        <= '0;
        end else begin
            tx_start   <= 1'b0;
            req_ack    <= '0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        grant_id <= arb_idx;
                        tx_data  <= req_arr[arb_idx];
                        tx_start <= 1'b1;
                        req_ack  <= NUM_REQ'(1) << arb_idx;
                        busy     <= 1'b1;
                        cnt      <= CNT_LOAD;
                        ptr      <= (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
                    end
                end
                SEND: begin
                    cnt <= cnt - 1'b1;
                end
                WAIT: begin
                    if (cnt == '0) begin
                        busy <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                    // Raise frame_done for the cycle in which the counter sits at zero.
                    frame_done <= (cnt == CNT_W'(1));
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
